// File: rtl/axis_text_framer.sv
// axis_text_framer: AXI4-Stream text sink that assembles a ROWS x COLS
// character frame in a back buffer and, on tlast, commits it to four
// registered line outputs for the OLED string-display stage.
module axis_text_framer #(
  parameter int         COLS     = 16,
  parameter int         ROWS     = 4,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [8*COLS-1:0] str1,
  output logic [8*COLS-1:0] str2,
  output logic [8*COLS-1:0] str3,
  output logic [8*COLS-1:0] str4,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = $clog2(ROWS + 1);
  // row counter reaches ROWS when the buffer is full
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic {
    RECV   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic              drop_reg;
  logic              frame_done_reg;
  logic              overflow_reg;
  logic [15:0]       frame_count_reg;
  logic [8*COLS-1:0] line_reg [ROWS];

  // back buffer cells, one byte each, flattened row-major
  logic [7:0]        cell_q [CELLS];
  logic [8*COLS-1:0] back_line [ROWS];

  // beat decode
  logic beat;
  logic is_print;
  logic is_lf;
  logic is_cr;
  logic is_ff;
  logic row_open;
  logic cell_wr;
  logic buf_clear;

  // Ready only in RECV and never while reset is held, so nothing is accepted
  // during the reset cycle and beats flow from the first cycle after it.
  assign s_axis_tready = (state_reg == RECV) && !rst;

  assign beat      = s_axis_tvalid && s_axis_tready;
  assign is_print  = (s_axis_tdata >= 8'h20) && (s_axis_tdata <= 8'h7E);
  assign is_lf     = (s_axis_tdata == 8'h0A);
  assign is_cr     = (s_axis_tdata == 8'h0D);
  assign is_ff     = (s_axis_tdata == 8'h0C);
  assign row_open  = (row_reg < ROW_FULL);
  assign cell_wr   = beat && is_print && row_open;
  // the buffer is wiped on form feed and on every commit
  assign buf_clear = (state_reg == COMMIT) || (beat && is_ff);

  // Each cell owns its own register: it loads the byte when the write
  // cursor points at it and falls back to PAD_CHAR on clear.
  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cell
      localparam logic [ROW_W-1:0] CELL_ROW = ROW_W'(gi / COLS);
      localparam logic [COL_W-1:0] CELL_COL = COL_W'(gi % COLS);
      logic [7:0] cell_reg;

      // cell storage: clear has priority over a write in the same cycle
      always_ff @(posedge clk) begin
        if (rst || buf_clear) begin
          cell_reg <= PAD_CHAR;
        end else if (cell_wr && (row_reg == CELL_ROW) && (col_reg == CELL_COL)) begin
          cell_reg <= s_axis_tdata;
        end
      end

      assign cell_q[gi] = cell_reg;
    end
  endgenerate

  // pack each buffer row into a line with column 0 in the MSBs
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      back_line[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        back_line[r][8*COLS-1-8*c -: 8] = cell_q[r*COLS + c];
      end
    end
  end

  // cursor/drop tracking, frame commit and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RECV;
      row_reg         <= '0;
      col_reg         <= '0;
      drop_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
      frame_count_reg <= 16'd0;
      for (int r = 0; r < ROWS; r++) begin
        line_reg[r] <= {COLS{PAD_CHAR}};
      end
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        RECV: begin
          if (beat) begin
            if (is_print) begin
              if (row_open) begin
                if (col_reg == COL_LAST) begin
                  col_reg <= '0;
                  row_reg <= row_reg + 1'b1;
                end else begin
                  col_reg <= col_reg + 1'b1;
                end
              end else begin
                // buffer already full: character is lost
                drop_reg <= 1'b1;
              end
            end else if (is_lf) begin
              col_reg <= '0;
              if (row_open) begin
                row_reg <= row_reg + 1'b1;
              end
            end else if (is_cr) begin
              col_reg <= '0;
            end else if (is_ff) begin
              // drop flag survives a form feed on purpose
              row_reg <= '0;
              col_reg <= '0;
            end
            if (s_axis_tlast) begin
              state_reg <= COMMIT;
            end
          end
        end
        COMMIT: begin
          for (int r = 0; r < ROWS; r++) begin
            line_reg[r] <= back_line[r];
          end
          frame_done_reg  <= 1'b1;
          overflow_reg    <= drop_reg;
          frame_count_reg <= frame_count_reg + 16'd1;
          row_reg         <= '0;
          col_reg         <= '0;
          drop_reg        <= 1'b0;
          state_reg       <= RECV;
        end
        default: begin
          state_reg <= RECV;
        end
      endcase
    end
  end

  assign str1        = line_reg[0];
  assign str2        = line_reg[1];
  assign str3        = line_reg[2];
  assign str4        = line_reg[3];
  assign frame_done  = frame_done_reg;
  assign overflow    = overflow_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_axis_text_framer.sv
// Bench for axis_text_framer: table of text frames with expected lines,
// driven through the stream port; expected frames are queued on tlast and
// popped when frame_done fires.
module tb_axis_text_framer;

  localparam int COLS = 16;
  localparam int LW   = 8 * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [LW-1:0] str1, str2, str3, str4;
  logic          frame_done;
  logic          overflow;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  axis_text_framer #(.COLS(COLS), .ROWS(4), .PAD_CHAR(8'h20)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .str1         (str1),
    .str2         (str2),
    .str3         (str3),
    .str4         (str4),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  typedef struct {
    string stim;
    string l1;
    string l2;
    string l3;
    string l4;
    bit    ovf;
    bit    rnd;
  } vec_t;

  typedef struct {
    logic [LW-1:0] line [4];
    bit            ovf;
    logic [15:0]   cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_count;
  vec_t        vecs [10];

  function automatic string ch(input logic [7:0] b);
    string t;
    t = " ";
    t.putc(0, b);
    return t;
  endfunction

  function automatic logic [LW-1:0] pad_line(input string s);
    logic [LW-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      v[LW-1-8*c -: 8] = (c < s.len()) ? s[c] : 8'h20;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Present one byte; optional idle gaps carry junk tdata and tlast=1 so a
  // DUT that ignores tvalid would be caught. Returns at the negedge after
  // the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input logic last, input bit rnd);
    int waitc;
    if (rnd) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'($urandom_range(8'h20, 8'h7E));
        s_axis_tlast  = 1'b1;
        @(negedge clk);
      end
    end
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    waitc = 0;
    while (!s_axis_tready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL tready_timeout: got 0 want 1 (byte %h)", b);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Wait for the commit pulse, pop the scoreboard and compare.
  task automatic wait_output();
    int   waitc;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    while (!frame_done && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_done_timeout: got 0 want 1");
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame: got frame_done with empty scoreboard want none");
    end else begin
      e = sb.pop_front();
      check("latency", LW'(waitc), LW'(0));
      check("str1", str1, e.line[0]);
      check("str2", str2, e.line[1]);
      check("str3", str3, e.line[2]);
      check("str4", str4, e.line[3]);
      check("overflow", LW'(overflow), LW'(e.ovf));
      check("frame_count", LW'(frame_count), LW'(e.cnt));
      $display("frame %0d: str1=%h ovf=%0b", frame_count, str1, overflow);
    end
    check("tready_after_commit", LW'(s_axis_tready), LW'(1));
    @(negedge clk);
    check("done_pulse_width", LW'(frame_done), LW'(0));
  endtask

  task automatic send_frame(input string s, input exp_t e, input bit rnd);
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) sb.push_back(e);
      send_byte(s[i], (i == s.len() - 1), rnd);
    end
    // now inside the commit cycle
    check("tready_commit", LW'(s_axis_tready), LW'(0));
    check("done_early", LW'(frame_done), LW'(0));
    wait_output();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string xs70, x16, k16, k17, s;
    logic [LW-1:0] blank;
    exp_t e;

    xs70 = "";
    for (int i = 0; i < 70; i++) xs70 = {xs70, "x"};
    x16 = "";
    for (int i = 0; i < 16; i++) x16 = {x16, "x"};
    k16 = "";
    for (int i = 0; i < 16; i++) k16 = {k16, "k"};
    k17 = {k16, "k"};
    blank = pad_line("");

    vecs[0] = '{"HELLO", "HELLO", "", "", "", 1'b0, 1'b0};
    vecs[1] = '{{"AB", ch(8'h0A), "C", ch(8'h0A), ch(8'h0A), "D"}, "AB", "C", "", "D", 1'b0, 1'b0};
    vecs[2] = '{xs70, x16, x16, x16, x16, 1'b1, 1'b0};
    vecs[3] = '{"Z", "Z", "", "", "", 1'b0, 1'b0};
    vecs[4] = '{{"ABC", ch(8'h0C), "Q"}, "Q", "", "", "", 1'b0, 1'b0};
    vecs[5] = '{ch(8'h0C), "", "", "", "", 1'b0, 1'b0};
    vecs[6] = '{{"AB", ch(8'h0D), "C", ch(8'h01), "D"}, "CD", "", "", "", 1'b0, 1'b0};
    vecs[7] = '{{ch(8'h0A), ch(8'h0A), ch(8'h0A), ch(8'h0A), ch(8'h0A)}, "", "", "", "", 1'b0, 1'b0};
    vecs[8] = '{k17, k16, "k", "", "", 1'b0, 1'b1};
    vecs[9] = '{{xs70, ch(8'h0C), "Y"}, "Y", "", "", "", 1'b1, 1'b0};

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    exp_count = 16'd0;
    repeat (3) @(negedge clk);

    check("rst_tready", LW'(s_axis_tready), LW'(0));
    check("rst_str1", str1, blank);
    check("rst_str4", str4, blank);
    check("rst_frame_done", LW'(frame_done), LW'(0));
    check("rst_overflow", LW'(overflow), LW'(0));
    check("rst_frame_count", LW'(frame_count), LW'(0));
    rst = 1'b0;
    #1;
    check("tready_after_rst", LW'(s_axis_tready), LW'(1));
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      exp_count = exp_count + 16'd1;
      e.line[0] = pad_line(vecs[v].l1);
      e.line[1] = pad_line(vecs[v].l2);
      e.line[2] = pad_line(vecs[v].l3);
      e.line[3] = pad_line(vecs[v].l4);
      e.ovf     = vecs[v].ovf;
      e.cnt     = exp_count;
      send_frame(vecs[v].stim, e, vecs[v].rnd);
    end

    // partial frame abandoned by reset
    s = "0123456789";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tready", LW'(s_axis_tready), LW'(0));
    @(negedge clk);
    check("midrst_str1", str1, blank);
    check("midrst_str2", str2, blank);
    check("midrst_str3", str3, blank);
    check("midrst_str4", str4, blank);
    check("midrst_frame_count", LW'(frame_count), LW'(0));
    check("midrst_overflow", LW'(overflow), LW'(0));
    rst = 1'b0;
    exp_count = 16'd0;
    #1;
    check("midrst_tready_release", LW'(s_axis_tready), LW'(1));
    @(negedge clk);

    exp_count = exp_count + 16'd1;
    e.line[0] = pad_line("AFTER");
    e.line[1] = blank;
    e.line[2] = blank;
    e.line[3] = blank;
    e.ovf     = 1'b0;
    e.cnt     = exp_count;
    send_frame("AFTER", e, 1'b0);

    check("scoreboard_empty", LW'(sb.size()), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
